// File: rtl/wm_pkg.sv
// Shared constants, weight type, FSM states and sigma helpers for the
// watermark embedding block.
package wm_pkg;

    localparam int SIGMA_FULL = 10000;
    localparam int Q_FRAC     = 10;
    localparam int DIV_W      = 24;

    typedef logic [10:0] q10_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_A,
        ST_DIV_B,
        ST_EMBED,
        ST_DRAIN
    } state_t;

    function automatic logic [13:0] clampSigma(input logic [13:0] s);
        return (s > 14'(SIGMA_FULL)) ? 14'(SIGMA_FULL) : s;
    endfunction

    // Weight span times clamped sigma; the result always fits the divider width.
    function automatic logic [DIV_W-1:0] scaleSpan(input int unsigned span, input logic [13:0] s);
        return DIV_W'(span * 32'(s));
    endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider: one quotient bit per cycle, DIV_W cycles per
// division, with the first bit resolved on the start cycle itself.
module seq_div
    import wm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] numerator,
    input  logic [13:0]      denominator,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [13:0]      rem_q;
    logic [13:0]      den_q;
    logic [DIV_W-1:0] quo_q;
    logic [4:0]       cnt_q;
    logic             active_q;
    logic             done_q;

    logic [13:0]      remIn;
    logic [13:0]      denIn;
    logic [DIV_W-1:0] quoIn;
    logic [14:0]      trial;
    logic             fits;
    logic [13:0]      rem_d;
    logic [DIV_W-1:0] quo_d;

    // A start overrides any division in flight and feeds the fresh operands
    // straight into the first step.
    always_comb begin
        remIn = rem_q;
        quoIn = quo_q;
        denIn = den_q;
        if (start) begin
            remIn = '0;
            quoIn = numerator;
            denIn = denominator;
        end
        trial = {remIn, quoIn[DIV_W-1]};
        fits  = (trial >= {1'b0, denIn});
        rem_d = fits ? 14'(trial - {1'b0, denIn}) : trial[13:0];
        quo_d = {quoIn[DIV_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            den_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            den_q    <= denominator;
            cnt_q    <= 5'(DIV_W - 1);
            active_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (active_q) begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_q - 5'd1;
            active_q <= (cnt_q != 5'd1);
            done_q   <= (cnt_q == 5'd1);
        end else begin
            done_q   <= 1'b0;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/wm_embed_block.sv
// Per-block watermark embedder: sigma -> (alpha, beta) via a shared divider, then
// a 2-stage alpha*host + beta*wm pipeline. EMBED_SATURATE_EN clamps instead of wrapping.
module wm_embed_block
    import wm_pkg::*;
#(
    parameter int ALPHA_MIN = 973,
    parameter int ALPHA_MAX = 1014,
    parameter int BETA_MIN  = 10,
    parameter int BETA_MAX  = 51
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] M,
    input  logic [13:0] sigma_in,
    input  logic       sigma_valid,
    input  logic [7:0] host_pixel,
    input  logic [7:0] wm_pixel,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] out_pixel,
    output logic       out_valid,
    output logic       block_done,
    output logic       busy
);

    localparam int unsigned ALPHA_SPAN = ALPHA_MAX - ALPHA_MIN;
    localparam int unsigned BETA_SPAN  = BETA_MAX - BETA_MIN;

    state_t      state_q;
    logic [13:0] sigma_q;
    logic [19:0] count_q;
    q10_t        alpha_q;
    q10_t        beta_q;
    logic        pixReady_q;
    logic        busy_q;
    logic        blockDone_q;

    logic [18:0] prodHost_q;
    logic [18:0] prodWm_q;
    logic        stage1Valid_q;
    logic        stage1Last_q;
    logic        outValid_q;
    logic [7:0]  outPixel_q;

    logic             divStart;
    logic             divDone;
    logic [DIV_W-1:0] divNum;
    logic [DIV_W-1:0] divQuo;
    logic             accept;
    logic             lastAccept;
    logic [20:0]      sum_d;
    logic [10:0]      r_d;
    logic [7:0]       pixel_d;

    seq_div u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (divStart),
        .numerator   (divNum),
        .denominator (14'(SIGMA_FULL)),
        .done        (divDone),
        .quotient    (divQuo)
    );

    // The alpha division launches on the sigma_valid cycle itself; the beta
    // division launches on the cycle the alpha quotient is taken.
    always_comb begin
        divStart = 1'b0;
        divNum   = '0;
        if (state_q == ST_IDLE && sigma_valid) begin
            divStart = 1'b1;
            divNum   = scaleSpan(ALPHA_SPAN, clampSigma(sigma_in));
        end else if (state_q == ST_DIV_A && divDone) begin
            divStart = 1'b1;
            divNum   = scaleSpan(BETA_SPAN, sigma_q);
        end
    end

    assign accept     = pix_valid && pixReady_q;
    assign lastAccept = accept && (count_q == 20'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sigma_q     <= '0;
            count_q     <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            pixReady_q  <= 1'b0;
            busy_q      <= 1'b0;
            blockDone_q <= 1'b0;
        end else begin
            blockDone_q <= stage1Last_q;
            case (state_q)
                ST_IDLE: begin
                    if (sigma_valid) begin
                        sigma_q <= clampSigma(sigma_in);
                        count_q <= 20'(M) * 20'(M);
                        busy_q  <= 1'b1;
                        state_q <= ST_DIV_A;
                    end
                end
                ST_DIV_A: begin
                    if (divDone) begin
                        alpha_q <= q10_t'(ALPHA_MIN) + q10_t'(divQuo);
                        state_q <= ST_DIV_B;
                    end
                end
                ST_DIV_B: begin
                    if (divDone) begin
                        beta_q <= q10_t'(BETA_MAX) - q10_t'(divQuo);
                        // An empty block finishes here with a lone done pulse.
                        if (count_q == '0) begin
                            blockDone_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            pixReady_q <= 1'b1;
                            state_q    <= ST_EMBED;
                        end
                    end
                end
                ST_EMBED: begin
                    if (accept) begin
                        count_q <= count_q - 20'd1;
                        if (count_q == 20'd1) begin
                            pixReady_q <= 1'b0;
                            state_q    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (stage1Last_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sum_d = 21'(prodHost_q) + 21'(prodWm_q) + 21'(1 << (Q_FRAC - 1));
        r_d   = 11'(sum_d >> Q_FRAC);
`ifdef EMBED_SATURATE_EN
        pixel_d = (r_d > 11'd255) ? 8'hFF : 8'(r_d);
`else
        pixel_d = 8'(r_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prodHost_q    <= '0;
            prodWm_q      <= '0;
            stage1Valid_q <= 1'b0;
            stage1Last_q  <= 1'b0;
            outValid_q    <= 1'b0;
            outPixel_q    <= '0;
        end else begin
            stage1Valid_q <= accept;
            stage1Last_q  <= lastAccept;
            if (accept) begin
                prodHost_q <= 19'(host_pixel) * 19'(alpha_q);
                prodWm_q   <= 19'(wm_pixel) * 19'(beta_q);
            end
            outValid_q <= stage1Valid_q;
            if (stage1Valid_q) begin
                outPixel_q <= pixel_d;
            end
        end
    end

    assign pix_ready  = pixReady_q;
    assign out_pixel  = outPixel_q;
    assign out_valid  = outValid_q;
    assign block_done = blockDone_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wm_embed_block.sv
// Table-driven, scoreboarded bench for wm_embed_block: a default instance plus
// one with widened alpha span for the overflow/saturation case.
module tb_wm_embed_block;

    typedef struct {
        int sigma;
        int m;
        int host;
        int wm;
        bit gaps;
        bit hi;
        bit randPix;
        int expPix;
    } vec_t;

    typedef struct {
        int pix;
        bit last;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        useHi    = 1'b0;
    logic [9:0]  mIn      = '0;
    logic [13:0] sigmaIn  = '0;
    logic        sigValid = 1'b0;
    logic [7:0]  hostIn   = '0;
    logic [7:0]  wmIn     = '0;
    logic        pixValid = 1'b0;

    logic loSigValid, hiSigValid, loPixValid, hiPixValid;
    logic loReady, loOutValid, loDone, loBusy;
    logic hiReady, hiOutValid, hiDone, hiBusy;
    logic [7:0] loPixel, hiPixel;
    logic pixReadyM, outValidM, blockDoneM, busyM;
    logic [7:0] outPixelM;

    assign loSigValid = sigValid & ~useHi;
    assign hiSigValid = sigValid & useHi;
    assign loPixValid = pixValid & ~useHi;
    assign hiPixValid = pixValid & useHi;
    assign pixReadyM  = useHi ? hiReady    : loReady;
    assign outValidM  = useHi ? hiOutValid : loOutValid;
    assign blockDoneM = useHi ? hiDone     : loDone;
    assign busyM      = useHi ? hiBusy     : loBusy;
    assign outPixelM  = useHi ? hiPixel    : loPixel;

    wm_embed_block dutLo (
        .clk         (clk),
        .rst         (rst),
        .M           (mIn),
        .sigma_in    (sigmaIn),
        .sigma_valid (loSigValid),
        .host_pixel  (hostIn),
        .wm_pixel    (wmIn),
        .pix_valid   (loPixValid),
        .pix_ready   (loReady),
        .out_pixel   (loPixel),
        .out_valid   (loOutValid),
        .block_done  (loDone),
        .busy        (loBusy)
    );

    wm_embed_block #(
        .ALPHA_MIN (973),
        .ALPHA_MAX (1024),
        .BETA_MIN  (51),
        .BETA_MAX  (51)
    ) dutHi (
        .clk         (clk),
        .rst         (rst),
        .M           (mIn),
        .sigma_in    (sigmaIn),
        .sigma_valid (hiSigValid),
        .host_pixel  (hostIn),
        .wm_pixel    (wmIn),
        .pix_valid   (hiPixValid),
        .pix_ready   (hiReady),
        .out_pixel   (hiPixel),
        .out_valid   (hiOutValid),
        .block_done  (hiDone),
        .busy        (hiBusy)
    );

    int   vecCount  = 0;
    int   errCount  = 0;
    int   cycCount  = 0;
    int   doneCount = 0;
    exp_t expQ[$];
    vec_t vecs[9];

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycCount);
        end
    endtask

    task automatic failNow(input string name);
        vecCount++;
        errCount++;
        $display("[TB] FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cycCount);
    endtask

    function automatic int modelPix(input int s, input int h, input int w, input bit hi);
        int amax, bmin, sc, a, b, r;
        amax = hi ? 1024 : 1014;
        bmin = hi ? 51 : 10;
        sc   = (s > 10000) ? 10000 : s;
        a    = 973 + ((amax - 973) * sc) / 10000;
        b    = 51 - ((51 - bmin) * sc) / 10000;
        r    = (h * a + w * b + 512) >>> 10;
`ifdef EMBED_SATURATE_EN
        return (r > 255) ? 255 : r;
`else
        return r & 255;
`endif
    endfunction

    always @(posedge clk) cycCount <= cycCount + 1;

    // Scoreboard: every out_valid pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (outValidM) begin
            if (expQ.size() == 0) begin
                failNow("unexpectedOutValid");
            end else begin
                e = expQ.pop_front();
                checkOutput("outPixel", int'(outPixelM), e.pix);
                checkOutput("blockDoneFlag", int'(blockDoneM), int'(e.last));
                checkOutput("outLatency", cycCount, e.cyc);
            end
        end
        if (blockDoneM) doneCount <= doneCount + 1;
    end

    task automatic applyStimulus(input vec_t v);
        int   total, sent, startCyc, doneBefore, guard, h, w;
        bit   phase;
        exp_t item;
        total      = v.m * v.m;
        doneBefore = doneCount;
        @(negedge clk);
        useHi    = v.hi;
        sigmaIn  = 14'(v.sigma);
        mIn      = 10'(v.m);
        sigValid = 1'b1;
        startCyc = cycCount + 1;
        @(negedge clk);
        sigValid = 1'b0;
        checkOutput("busyAfterStart", int'(busyM), 1);
        guard = 0;
        if (total == 0) begin
            while (!blockDoneM && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!blockDoneM) begin
                failNow("emptyBlockDone");
            end else begin
                checkOutput("emptyDoneCycle", cycCount, startCyc + 48);
                checkOutput("emptyNoOutValid", int'(outValidM), 0);
            end
        end else begin
            while (!pixReadyM && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!pixReadyM) failNow("pixReadyRise");
            else checkOutput("pixReadyCycle", cycCount, startCyc + 48);
            sent  = 0;
            phase = 1'b0;
            guard = 0;
            while (sent < total && guard < 1000) begin
                if (v.gaps && phase) begin
                    // Idle pair slot; a stray sigma_valid here must be ignored.
                    pixValid = 1'b0;
                    sigValid = 1'b1;
                    sigmaIn  = 14'd10000;
                end else if (pixReadyM) begin
                    sigValid  = 1'b0;
                    h         = v.randPix ? int'($urandom_range(0, 255)) : v.host;
                    w         = v.randPix ? int'($urandom_range(0, 255)) : v.wm;
                    item.pix  = v.randPix ? modelPix(v.sigma, h, w, v.hi) : v.expPix;
                    item.last = (sent == total - 1);
                    item.cyc  = cycCount + 2;
                    expQ.push_back(item);
                    hostIn   = 8'(h);
                    wmIn     = 8'(w);
                    pixValid = 1'b1;
                    sent++;
                end else begin
                    pixValid = 1'b0;
                end
                phase = ~phase;
                @(negedge clk);
                guard++;
            end
            pixValid = 1'b0;
            sigValid = 1'b0;
            if (sent < total) failNow("pairsAccepted");
            checkOutput("pixReadyDrop", int'(pixReadyM), 0);
            guard = 0;
            while (doneCount == doneBefore && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("donePulses", doneCount - doneBefore, 1);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        checkOutput("busyIdle", int'(busyM), 0);
    endtask

    initial begin
        int satExp;
        int guard;
        int doneBefore;
        exp_t item;
`ifdef EMBED_SATURATE_EN
        satExp = 255;
`else
        satExp = 12;
`endif
        //          sigma  M  host wm  gaps hi rand exp
        vecs[0] = '{0,     2, 200, 255, 0,  0, 0,   203};
        vecs[1] = '{10000, 1, 200, 255, 0,  0, 0,   201};
        vecs[2] = '{16383, 1, 200, 255, 0,  0, 0,   201};
        vecs[3] = '{5000,  3, 100, 128, 1,  0, 0,   101};
        vecs[4] = '{2500,  2, 255, 255, 0,  0, 0,   255};
        vecs[5] = '{10000, 1, 255, 255, 0,  1, 0,   satExp};
        vecs[6] = '{0,     0, 0,   0,   0,  0, 0,   0};
        vecs[7] = '{int'($urandom_range(0, 16383)), 2, 0, 0, 0, 0, 1, 0};
        vecs[8] = '{int'($urandom_range(0, 10000)), 3, 0, 0, 0, 0, 1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetPixReady", int'(loReady), 0);
        checkOutput("resetOutValid", int'(loOutValid), 0);
        checkOutput("resetBlockDone", int'(loDone), 0);
        checkOutput("resetBusy", int'(loBusy), 0);
        checkOutput("resetOutPixel", int'(loPixel), 0);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] block %0d: sigma=%0d M=%0d", i, vecs[i].sigma, vecs[i].m);
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a 3x3 block after five accepted pairs.
        $display("[TB] mid-block reset sequence");
        doneBefore = doneCount;
        @(negedge clk);
        useHi    = 1'b0;
        sigmaIn  = 14'd0;
        mIn      = 10'd3;
        sigValid = 1'b1;
        @(negedge clk);
        sigValid = 1'b0;
        guard    = 0;
        while (!loReady && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!loReady) failNow("resetSeqPixReady");
        for (int k = 0; k < 5; k++) begin
            hostIn    = 8'd200;
            wmIn      = 8'd255;
            pixValid  = 1'b1;
            item.pix  = 203;
            item.last = 1'b0;
            item.cyc  = cycCount + 2;
            expQ.push_back(item);
            @(negedge clk);
        end
        pixValid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checkOutput("midResetPixReady", int'(loReady), 0);
        checkOutput("midResetOutValid", int'(loOutValid), 0);
        checkOutput("midResetBlockDone", int'(loDone), 0);
        checkOutput("midResetBusy", int'(loBusy), 0);
        checkOutput("midResetOutPixel", int'(loPixel), 0);
        checkOutput("midResetInFlight", expQ.size(), 1);
        checkOutput("midResetNoDone", doneCount - doneBefore, 0);
        expQ.delete();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] block after reset: sigma=%0d M=%0d", vecs[8].sigma, vecs[8].m);
        applyStimulus(vecs[8]);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #500000;
        errCount++;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit (cycle %0d)", cycCount);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
